// File: rtl/regs_file_param.sv
// regs_file_param: NIDX index registers plus stack pointer S on a precharged wired-AND special bus
//   PHI2, n_RES             : clock (rising edge), asynchronous active-low reset
//   sb_in                   : external SB value, all ones when undriven
//   idx_sb, sb_idx          : per index register drive-SB / load-from-SB enables
//   s_sb, s_adl, sb_s       : S drives SB / S drives ADL / S loads from SB
//   s_inc, s_dec            : S increment / decrement, modulo 2^WIDTH
//   err_clr                 : synchronous clear of the sticky conflict flag
//   sb_out, sb_oe           : resolved SB value, high when this block drives SB
//   adl_out, adl_oe         : S on ADL (all ones when not driving), drive flag
//   s_q, err                : current S, sticky S-command-conflict flag
module regs_file_param #(
    parameter int WIDTH = 8,
    parameter int NIDX = 2,
    parameter logic [WIDTH-1:0] S_RESET = {WIDTH{1'b1}}
) (
    input  logic             PHI2,
    input  logic             n_RES,
    input  logic [WIDTH-1:0] sb_in,
    input  logic [NIDX-1:0]  idx_sb,
    input  logic [NIDX-1:0]  sb_idx,
    input  logic             s_sb,
    input  logic             s_adl,
    input  logic             sb_s,
    input  logic             s_inc,
    input  logic             s_dec,
    input  logic             err_clr,
    output logic [WIDTH-1:0] sb_out,
    output logic             sb_oe,
    output logic [WIDTH-1:0] adl_out,
    output logic             adl_oe,
    output logic [WIDTH-1:0] s_q,
    output logic             err
);
    logic [WIDTH-1:0] idx_q [NIDX];
    logic [WIDTH-1:0] s_next;
    logic             conflict;

    // Undriven contributors read as all ones so the AND reduces to the active drivers only.
    always_comb begin
        sb_out = sb_in & (s_sb ? s_q : {WIDTH{1'b1}});
        for (int i = 0; i < NIDX; i++)
            sb_out = sb_out & (idx_sb[i] ? idx_q[i] : {WIDTH{1'b1}});
    end

    assign sb_oe    = |idx_sb | s_sb;
    assign adl_out  = s_adl ? s_q : {WIDTH{1'b1}};
    assign adl_oe   = s_adl;
    assign conflict = (sb_s & s_inc) | (sb_s & s_dec) | (s_inc & s_dec);

    // Simultaneous inc and dec cancel to a hold; the bus load outranks both.
    assign s_next = sb_s             ? sb_out :
                    s_inc && !s_dec  ? s_q + 1'b1 :
                    s_dec && !s_inc  ? s_q - 1'b1 : s_q;

    always_ff @(posedge PHI2 or negedge n_RES) begin
        if (!n_RES) begin
            for (int i = 0; i < NIDX; i++)
                idx_q[i] <= '0;
            s_q <= S_RESET;
            err <= 1'b0;
        end else begin
            for (int i = 0; i < NIDX; i++)
                if (sb_idx[i])
                    idx_q[i] <= sb_out;
            s_q <= s_next;
            err <= conflict | (err & ~err_clr);
        end
    end
endmodule

// File: tb/tb_regs_file_param.sv
// tb_regs_file_param: scoreboard bench for regs_file_param (WIDTH=8, NIDX=2)
module tb_regs_file_param;
    logic       PHI2 = 1'b0;
    logic       n_RES;
    logic [7:0] sb_in;
    logic [1:0] idx_sb, sb_idx;
    logic       s_sb, s_adl, sb_s, s_inc, s_dec, err_clr;
    logic [7:0] sb_out, adl_out, s_q;
    logic       sb_oe, adl_oe, err;

    int checks = 0;
    int errors = 0;
    string      tag_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] mx, my, ms, msb;
    logic       merr;

    regs_file_param #(.WIDTH(8), .NIDX(2)) dut (
        .PHI2(PHI2), .n_RES(n_RES), .sb_in(sb_in), .idx_sb(idx_sb), .sb_idx(sb_idx),
        .s_sb(s_sb), .s_adl(s_adl), .sb_s(sb_s), .s_inc(s_inc), .s_dec(s_dec),
        .err_clr(err_clr), .sb_out(sb_out), .sb_oe(sb_oe), .adl_out(adl_out),
        .adl_oe(adl_oe), .s_q(s_q), .err(err)
    );

    always #5 PHI2 = ~PHI2;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [7:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic pop(input logic [7:0] obs);
        if (exp_q.size() == 0) chk("scoreboard_empty", 8'd1, 8'd0);
        else chk(tag_q.pop_front(), obs, exp_q.pop_front());
    endtask

    task automatic idle();
        sb_in = 8'hFF; idx_sb = 2'b00; sb_idx = 2'b00;
        s_sb = 0; s_adl = 0; sb_s = 0; s_inc = 0; s_dec = 0; err_clr = 0;
    endtask

    task automatic tick();
        @(posedge PHI2);
        #1;
    endtask

    initial begin
        n_RES = 1'b0;
        idle();
        sb_in = 8'hA5;
        tick(); tick();
        #1;
        push("rst_s", 8'hFF);    pop(s_q);
        push("rst_err", 8'h00);  pop({7'd0, err});
        push("rst_adl", 8'hFF);  pop(adl_out);
        push("rst_sb", 8'hA5);   pop(sb_out);
        push("rst_sb_oe", 8'h00); pop({7'd0, sb_oe});
        sb_in = 8'hFF; idx_sb = 2'b01; #1;
        push("rst_x", 8'h00); pop(sb_out);
        idx_sb = 2'b10; #1;
        push("rst_y", 8'h00); pop(sb_out);
        idle();
        n_RES = 1'b1;

        // X <= 5A, then X -> S in one cycle
        tick(); sb_in = 8'h5A; sb_idx = 2'b01;
        tick(); idle(); idx_sb = 2'b01; sb_s = 1;
        #1; push("xfer_sb", 8'h5A); pop(sb_out);
        tick(); idle();
        push("xfer_s", 8'h5A); pop(s_q);
        s_adl = 1; #1;
        push("adl_out", 8'h5A); pop(adl_out);
        push("adl_oe", 8'h01);  pop({7'd0, adl_oe});
        idle();

        // wired-AND of two drivers
        tick(); sb_in = 8'hF0; sb_idx = 2'b01;
        tick(); sb_in = 8'h3C; sb_idx = 2'b10;
        tick(); idle(); idx_sb = 2'b11; #1;
        push("wand_ff", 8'h30); pop(sb_out);
        push("wand_oe", 8'h01); pop({7'd0, sb_oe});
        sb_in = 8'h7F; #1;
        push("wand_7f", 8'h30); pop(sb_out);
        idle();

        // wrap-around
        sb_in = 8'hFF; sb_s = 1;
        tick(); idle(); s_inc = 1;
        tick(); idle();
        push("wrap_inc", 8'h00); pop(s_q);
        s_dec = 1;
        tick(); idle();
        push("wrap_dec", 8'hFF); pop(s_q);

        // conflicts
        s_inc = 1; s_dec = 1;
        tick(); idle();
        push("conf_s", 8'hFF);  pop(s_q);
        push("conf_err", 8'h01); pop({7'd0, err});
        err_clr = 1; sb_s = 1; s_dec = 1; sb_in = 8'h42;
        tick(); idle();
        push("setwins_err", 8'h01); pop({7'd0, err});
        push("setwins_s", 8'h42);   pop(s_q);
        err_clr = 1;
        tick(); idle();
        push("clr_err", 8'h00); pop({7'd0, err});

        // read-during-write on Y
        sb_in = 8'h11; sb_idx = 2'b10;
        tick(); idle(); idx_sb = 2'b10; sb_idx = 2'b10; sb_in = 8'h0F; #1;
        push("rdw_before", 8'h01); pop(sb_out);
        tick(); idle(); idx_sb = 2'b10; #1;
        push("rdw_after", 8'h01); pop(sb_out);

        // asynchronous reset mid-cycle
        #2 n_RES = 1'b0;
        #1;
        push("arst_y", 8'h00); pop(sb_out);
        push("arst_s", 8'hFF); pop(s_q);
        #2 n_RES = 1'b1;
        idle();

        // random traffic against a reference model
        mx = 8'h00; my = 8'h00; ms = 8'hFF; merr = 1'b0;
        for (int n = 0; n < 300; n++) begin
            tick();
            sb_in = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            idx_sb = 2'($urandom); sb_idx = 2'($urandom);
            s_sb = 1'($urandom); s_adl = 1'($urandom);
            sb_s = ($urandom_range(0, 3) == 0); s_inc = ($urandom_range(0, 2) == 0);
            s_dec = ($urandom_range(0, 2) == 0); err_clr = ($urandom_range(0, 5) == 0);
            msb = sb_in;
            if (idx_sb[0]) msb &= mx;
            if (idx_sb[1]) msb &= my;
            if (s_sb) msb &= ms;
            #1;
            push("rnd_sb", msb); pop(sb_out);
            push("rnd_sb_oe", {7'd0, (idx_sb != 2'b00) || s_sb}); pop({7'd0, sb_oe});
            push("rnd_adl", s_adl ? ms : 8'hFF); pop(adl_out);
            if (sb_idx[0]) mx = msb;
            if (sb_idx[1]) my = msb;
            merr = ($countones({sb_s, s_inc, s_dec}) > 1) || (merr && !err_clr);
            if (sb_s) ms = msb;
            else if (s_inc != s_dec) ms = s_inc ? ms + 8'd1 : ms - 8'd1;
            tick();
            push("rnd_s", ms);             pop(s_q);
            push("rnd_err", {7'd0, merr}); pop({7'd0, err});
            idle();
        end

        if (exp_q.size() != 0) chk("scoreboard_left", 8'(exp_q.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regs_file_param.md
# regs_file_param

Parametrised successor to the 6502 X/Y/S register block: NIDX index registers plus one stack pointer S, each WIDTH bits, all connected to a precharged wired-AND special bus (SB), with S also able to drive the ADL bus. Unlike the fixed 8-bit version, it adds an asynchronous reset, on-chip S increment/decrement with wrap-around, single-cycle register-to-register transfers over SB, and a sticky conflict flag for illegal S command combinations. It sits between the decoder's control lines and the SB/ADL bus muxes in the core datapath.

## Interface
- WIDTH, 8, bit width of every register and bus.
- NIDX, 2, number of index registers (index 0 = X, 1 = Y); legal range 1..8.
- S_RESET, all ones, value loaded into S on reset.
- PHI2  in  1  clock; all state updates on rising edge.
- n_RES  in  1  asynchronous active-low reset.
- sb_in  in  WIDTH  value driven on SB by external agents; all ones when no external driver.
- idx_sb  in  NIDX  per-register enable: index register i drives SB.
- sb_idx  in  NIDX  per-register enable: index register i loads from SB.
- s_sb  in  1  S drives SB.
- s_adl  in  1  S drives ADL.
- sb_s  in  1  S loads from SB.
- s_inc  in  1  S <= S + 1.
- s_dec  in  1  S <= S - 1.
- err_clr  in  1  synchronous clear of err.
- sb_out  out  WIDTH  resolved SB value.
- sb_oe  out  1  high when any register in this block drives SB.
- adl_out  out  WIDTH  S when s_adl, else all ones.
- adl_oe  out  1  equals s_adl.
- s_q  out  WIDTH  current S (debug).
- err  out  1  sticky S-command-conflict flag.

## Operation
- Bus resolution (combinational): sb_out = sb_in AND (AND of every register whose drive enable is high). No internal drivers -> sb_out = sb_in. Multiple drivers legal (wired-AND, as on NMOS precharged bus).
- sb_oe = OR(idx_sb) OR s_sb.
- Index register i: if sb_idx[i], loads sb_out at rising edge; else holds. Multiple sb_idx bits may be high; all load the same value.
- S command priority at rising edge: sb_s -> S <= sb_out; else s_inc only -> S + 1; else s_dec only -> S - 1; else s_inc and s_dec both -> hold; else hold.
- Arithmetic modulo 2^WIDTH: all ones + 1 = 0; 0 - 1 = all ones. No carry/borrow output.
- Conflict: more than one of {sb_s, s_inc, s_dec} high at a rising edge sets err next cycle. err holds until err_clr. Set wins over clear in the same cycle.
- Read-during-write: a register driving SB while loading shows the old value on sb_out in that cycle; the new value appears after the edge. Thus X->S, S->Y etc. complete in one cycle.
- Reset: asynchronous assertion forces all index registers to 0, S to S_RESET, and err to 0 immediately. Outputs follow combinationally: with all enables low, sb_out = sb_in and adl_out = all ones. Deassertion is synchronised externally. The first update is on the first rising edge with n_RES high.

## Timing
- Bus outputs (sb_out, sb_oe, adl_out, adl_oe) are combinational from enables, sb_in and register state; no added latency.
- Register updates: 1 cycle. A value loaded at edge k is visible on sb_out/adl_out/s_q after edge k.
- err: asserted the cycle after the conflicting edge. Reset mid-operation discards any pending update.
- Combinational path sb_in -> sb_out -> register D must close in one PHI2 period. No combinational path from any output back to any input.

## Test plan
- Reset: n_RES low with PHI2 running -> X=Y=0, s_q=8'hFF, err=0, adl_out=8'hFF, sb_out=sb_in.
- Load/transfer: sb_in=8'h5A, sb_idx=2'b01 for one edge. Then idx_sb=2'b01, sb_s=1, sb_in=8'hFF for one edge -> s_q=8'h5A. With s_adl=1 -> adl_out=8'h5A, adl_oe=1.
- Wired-AND: X=8'hF0, Y=8'h3C, idx_sb=2'b11, sb_in=8'hFF -> sb_out=8'h30, sb_oe=1. Repeat with sb_in=8'h7F -> sb_out=8'h30.
- Wrap: S=8'hFF, s_inc one edge -> 8'h00. Then s_dec one edge -> 8'hFF.
- Conflict: s_inc=s_dec=1 one edge -> S unchanged, err=1 next cycle. err_clr and sb_s+s_dec together -> err stays 1 and S <= sb_out. err_clr alone -> err=0.
- Read-during-write and async reset: Y=8'h11, idx_sb[1]=sb_idx[1]=1, sb_in=8'h0F -> sb_out=8'h01 before the edge, Y=8'h01 after. n_RES pulsed low mid-cycle -> Y=0, S=8'hFF without waiting for an edge.
